// File: rtl/mem_ctrl.sv
// Byte-serial sequencer/arbiter for the shared RAM/IO port: splits icache fetches and
// LSB loads/stores into consecutive byte cycles and reassembles read data little-endian.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  inst_require_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    output logic                  inst_busy_o,
    output logic                  inst_enable_o,
    output logic [31:0]           inst_data_o,
    input  logic                  data_require_i,
    input  logic                  data_wr_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [1:0]            data_size_i,
    input  logic [31:0]           data_i,
    output logic                  data_enable_o,
    output logic [31:0]           data_o,
    input  logic                  io_buffer_full,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INST_RD = 2'd1,
        DATA_RD = 2'd2,
        DATA_WR = 2'd3
    } state_t;

    localparam logic [2:0] INST_N = 3'(INST_BYTES);

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = w[7:0];
            3'd1:    b = w[15:8];
            3'd2:    b = w[23:16];
            3'd3:    b = w[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            3'd0:    r[7:0]   = b;
            3'd1:    r[15:8]  = b;
            3'd2:    r[23:16] = b;
            3'd3:    r[31:24] = b;
            default: r = w;
        endcase
        return r;
    endfunction

    // Size code 2'b11 is not a legal access width and is serviced as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] code);
        logic [2:0] n;
        case (code)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    state_t                state_r, state_s;
    logic [2:0]            cnt_r, cnt_s;
    logic [2:0]            size_r, size_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [31:0]           wdata_r, wdata_s;
    logic [31:0]           rdata_r, rdata_s;

    logic [ADDR_WIDTH-1:0] mem_a_s;
    logic                  mem_wr_s;
    logic [7:0]            mem_dout_s;
    logic                  inst_en_s, data_en_s, busy_s;
    logic [31:0]           inst_data_s, data_s;

    logic                  io_stall_s, data_go_s, inst_go_s;
    logic [2:0]            cnt_nx_s, cnt_m1_s;
    logic                  last_rd_s, more_s;
    logic [ADDR_WIDTH-1:0] cnt_ext_s;

    // A blocked IO store still owns arbitration so a younger fetch cannot overtake it.
    assign io_stall_s = data_require_i & data_wr_i & (data_addr_i[17:16] == 2'b11) & io_buffer_full;
    assign data_go_s  = data_require_i & ~io_stall_s;
    assign inst_go_s  = ~data_require_i & inst_require_i & ~clear_i;
    assign cnt_nx_s   = cnt_r + 3'd1;
    assign cnt_m1_s   = cnt_r - 3'd1;
    assign last_rd_s  = (cnt_r == size_r);
    assign more_s     = (cnt_nx_s < size_r);
    assign cnt_ext_s  = {{(ADDR_WIDTH-3){1'b0}}, cnt_nx_s};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: arbitration in IDLE, byte sequencing elsewhere.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (data_go_s) begin
                    if (data_wr_i) state_s = DATA_WR;
                    else           state_s = DATA_RD;
                end else if (inst_go_s) begin
                    state_s = INST_RD;
                end else begin
                    state_s = IDLE;
                end
            end
            INST_RD: begin
                if (clear_i || last_rd_s) state_s = IDLE;
                else                      state_s = INST_RD;
            end
            DATA_RD: begin
                if (last_rd_s) state_s = IDLE;
                else           state_s = DATA_RD;
            end
            DATA_WR: begin
                if (!more_s) state_s = IDLE;
                else         state_s = DATA_WR;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output/datapath next values; pins change one cycle after the decision.
    always_comb begin
        cnt_s       = cnt_r;
        size_s      = size_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        rdata_s     = rdata_r;
        mem_a_s     = {ADDR_WIDTH{1'b0}};
        mem_wr_s    = 1'b0;
        mem_dout_s  = 8'd0;
        inst_en_s   = 1'b0;
        data_en_s   = 1'b0;
        inst_data_s = inst_data_o;
        data_s      = data_o;
        busy_s      = (state_s != IDLE);
        case (state_r)
            IDLE: begin
                if (data_go_s) begin
                    addr_s  = data_addr_i;
                    size_s  = size_bytes(data_size_i);
                    wdata_s = data_i;
                    rdata_s = 32'd0;
                    cnt_s   = 3'd0;
                    mem_a_s = data_addr_i;
                    if (data_wr_i) begin
                        mem_wr_s   = 1'b1;
                        mem_dout_s = data_i[7:0];
                    end else begin
                        mem_wr_s   = 1'b0;
                    end
                end else if (inst_go_s) begin
                    addr_s  = inst_addr_i;
                    size_s  = INST_N;
                    rdata_s = 32'd0;
                    cnt_s   = 3'd0;
                    mem_a_s = inst_addr_i;
                end else begin
                    cnt_s   = 3'd0;
                end
            end
            INST_RD, DATA_RD: begin
                // RAM read data lags its address by one cycle, so byte k lands at cnt k+1.
                cnt_s = cnt_nx_s;
                if (cnt_r != 3'd0) rdata_s = put_byte(rdata_r, cnt_m1_s, mem_din);
                else               rdata_s = rdata_r;
                if ((state_r == INST_RD) && clear_i) begin
                    cnt_s = 3'd0;
                end else if (last_rd_s) begin
                    cnt_s = 3'd0;
                    if (state_r == INST_RD) begin
                        inst_en_s   = 1'b1;
                        inst_data_s = rdata_s;
                    end else begin
                        data_en_s   = 1'b1;
                        data_s      = rdata_s;
                    end
                end else if (more_s) begin
                    mem_a_s = addr_r + cnt_ext_s;
                end else begin
                    mem_a_s = {ADDR_WIDTH{1'b0}};
                end
            end
            DATA_WR: begin
                cnt_s = cnt_nx_s;
                if (more_s) begin
                    mem_wr_s   = 1'b1;
                    mem_a_s    = addr_r + cnt_ext_s;
                    mem_dout_s = get_byte(wdata_r, cnt_nx_s);
                end else begin
                    cnt_s     = 3'd0;
                    data_en_s = 1'b1;
                end
            end
            default: begin
                cnt_s = 3'd0;
            end
        endcase
    end

    // Registered outputs and access context.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r         <= 3'd0;
            size_r        <= 3'd0;
            addr_r        <= {ADDR_WIDTH{1'b0}};
            wdata_r       <= 32'd0;
            rdata_r       <= 32'd0;
            mem_a         <= {ADDR_WIDTH{1'b0}};
            mem_wr        <= 1'b0;
            mem_dout      <= 8'd0;
            inst_enable_o <= 1'b0;
            data_enable_o <= 1'b0;
            inst_data_o   <= 32'd0;
            data_o        <= 32'd0;
            inst_busy_o   <= 1'b0;
        end else begin
            cnt_r         <= cnt_s;
            size_r        <= size_s;
            addr_r        <= addr_s;
            wdata_r       <= wdata_s;
            rdata_r       <= rdata_s;
            mem_a         <= mem_a_s;
            mem_wr        <= mem_wr_s;
            mem_dout      <= mem_dout_s;
            inst_enable_o <= inst_en_s;
            data_enable_o <= data_en_s;
            inst_data_o   <= inst_data_s;
            data_o        <= data_s;
            inst_busy_o   <= busy_s;
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sequencer and arbiter for the single byte-wide RAM/IO port, shared between the instruction cache (fetch misses) and the load/store path (data reads and writes).
- Splits each 1/2/4-byte access into consecutive byte cycles and reassembles read data little-endian.
- Reports fetch completion and busy status back to the icache.
- Sits between icache/LSB and the top-level memory pins.

Parameters:
ADDR_WIDTH, 32, width of all address ports
INST_BYTES, 4, bytes per instruction fetch

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
clear_i  in  1  pipeline flush; aborts an in-flight instruction fetch
inst_require_i  in  1  icache miss request, level, held until serviced or dropped
inst_addr_i  in  32  fetch address
inst_busy_o  out  1  controller not idle (icache inst_busy)
inst_enable_o  out  1  one-cycle pulse: fetched word valid (icache inst_enable_i)
inst_data_o  out  32  fetched instruction
data_require_i  in  1  load/store request, level, held until data_enable_o
data_wr_i  in  1  1=store, 0=load
data_addr_i  in  32  byte address
data_size_i  in  2  00=1B, 01=2B, 10=4B; 11 treated as 4B
data_i  in  32  store data, byte k = data_i[8k+7:8k]
data_enable_o  out  1  one-cycle pulse: access complete
data_o  out  32  load result, zero-extended
io_buffer_full  in  1  IO output FIFO full
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1=write

Behaviour:
- All outputs are registered. Reset (rst low, async) forces: state IDLE, counter 0, every output 0. Reset mid-access abandons it; no completion pulse follows.
- States: IDLE, INST_RD, DATA_RD, DATA_WR.
- IDLE arbitration, sampled at the edge ending cycle T:
  - data_require_i has priority over inst_require_i.
  - A store to IO space (data_addr_i[17:16]==2'b11) while io_buffer_full=1 is not started; the controller stays IDLE. An instruction request is still not granted that cycle, so order is preserved.
- Latch addr, size N (4 for fetch), store data; counter k=0.
- Read (INST_RD/DATA_RD):
  - mem_a=addr+k, mem_wr=0 in cycle T+1+k, for k=0..N-1.
  - Byte k is valid on mem_din in cycle T+2+k and is captured into result[8k+7:8k] at the end of that cycle.
  - After the last byte (cycle T+N+1), the matching enable pulses in cycle T+N+2 with data, and the state is IDLE in that same cycle.
  - Full fetch: request at T -> inst_enable_o at T+6.
- Write (DATA_WR):
  - In cycle T+1+k: mem_wr=1, mem_a=addr+k, mem_dout=byte k.
  - data_enable_o pulses in cycle T+N+1, and the state is IDLE in that cycle.
- A new request may be accepted in the IDLE cycle carrying the enable pulse. Requesters must drop or change the request on the pulse.
- When not accessing: mem_a=0, mem_wr=0, mem_dout=0.
- inst_busy_o=1 whenever state!=IDLE.
- inst_data_o and data_o hold their last value after the pulse. Enables are low except for the single pulse cycle.
- clear_i:
  - In INST_RD, including the cycle the last byte arrives: next state IDLE, no inst_enable_o, mem_a/mem_wr return to 0.
  - In IDLE it blocks granting an instruction request that cycle.
  - No effect on DATA_RD/DATA_WR.
- Address arithmetic is modulo 2^ADDR_WIDTH; addr+k wraps 0xFFFFFFFF -> 0x0.
- Unaligned accesses are allowed; bytes are simply consecutive.

Test Plan:
1. Fetch: reset release, inst_require_i=1, addr 0x1000, RAM bytes 13,05,00,00 -> mem_a 0x1000..0x1003 in cycles T+1..T+4; inst_enable_o pulses at T+6 with 0x00000513; inst_busy_o high T+1..T+5.
2. Simultaneous: inst and data (load, 2B, addr 0x2002, bytes AB,CD) requested together -> data serviced first, data_o=0x0000CDAB; the fetch then starts in the pulse cycle.
3. Store 4B 0xDEADBEEF to 0x3000 -> mem_wr=1 with EF,BE,AD,DE at 0x3000..0x3003; data_enable_o one cycle after the last byte; mem_wr=0 afterwards.
4. IO stall: store 1B to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 and state stays IDLE; the write is issued the cycle after full drops.
5. Flush: clear_i pulsed during cycle T+3 of a fetch -> no inst_enable_o, state IDLE next cycle, a new fetch is accepted afterwards; clear_i during a store -> store completes normally.
6. Async reset asserted mid-load -> all outputs 0 immediately; no data_enable_o after release. Wrap test: 4B load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
